// File: rtl/dram_sched_ctrl_if.sv
// Request-port and DRAM command/data bundle for dram_sched_ctrl.
// The slave side is the scheduler; the master side is the requester/array side.
interface dram_sched_ctrl_if #(
  parameter int NUM_REQ    = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 22,
  parameter int BANK_W     = 3,
  parameter int ROW_W      = 7,
  parameter int COL_W      = 3
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_rw;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [2:0]                    dram_cmd;
  logic [BANK_W-1:0]             dram_bank;
  logic [ROW_W-1:0]              dram_row;
  logic [COL_W-1:0]              dram_col;
  logic [DATA_WIDTH-1:0]         dram_wdata;
  logic [DATA_WIDTH-1:0]         dram_rdata;
  logic                          refresh_busy;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, dram_rdata,
    output req_ready, rsp_valid, rsp_data, dram_cmd, dram_bank, dram_row,
           dram_col, dram_wdata, refresh_busy
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, dram_rdata,
    input  req_ready, rsp_valid, rsp_data, dram_cmd, dram_bank, dram_row,
           dram_col, dram_wdata, refresh_busy
  );
endinterface

// File: rtl/dram_sched_ctrl.sv
// Multi-channel DRAM command scheduler: round-robin request arbitration,
// open-page bank tracking, programmable ACT/PRE/RD/WR timing and periodic refresh.
//
// state      | meaning
// IDLE       | ready to grant a request or start a pending refresh
// ACT        | ACT on the bus; opens bank/row
// RCD_WAIT   | remaining ACT->RD/WR delay
// ACCESS     | RD or WR on the bus
// CL_WAIT    | waiting for read data; sampled on the last cycle
// PRE        | PRE on the bus; closes the bank
// RP_WAIT    | remaining PRE->ACT delay
// RACK       | rsp_valid pulse to the granted channel
// PREA       | PREA on the bus before refresh
// PREA_WAIT  | remaining PREA->REF delay
// REF        | REF on the bus; clears open table and pending flag
// RFC_WAIT   | remaining REF->IDLE delay
module dram_sched_ctrl #(
  parameter int NUM_REQ          = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int NUM_OF_BANKS     = 8,
  parameter int NUM_OF_ROWS      = 128,
  parameter int NUM_OF_COLS      = 8,
  parameter int ADDR_WIDTH       = 22,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_CL             = 2,
  parameter int T_RFC            = 8,
  parameter int REFRESH_INTERVAL = 1024
) (
  input logic             clk,
  input logic             rst,
  dram_sched_ctrl_if.slave bus
);
  localparam int BANK_W  = $clog2(NUM_OF_BANKS);
  localparam int ROW_W   = $clog2(NUM_OF_ROWS);
  localparam int COL_W   = $clog2(NUM_OF_COLS);
  localparam int CH_W    = $clog2(NUM_REQ);
  localparam int T_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX_B = (T_CL > T_RFC) ? T_CL : T_RFC;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CNT_W   = $clog2(T_MAX + 1);
  localparam int RI_W    = $clog2(REFRESH_INTERVAL);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_RCD_WAIT, S_ACCESS, S_CL_WAIT, S_PRE, S_RP_WAIT,
    S_RACK, S_PREA, S_PREA_WAIT, S_REF, S_RFC_WAIT
  } state_t;

  state_t                  state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [CH_W-1:0]         rr_ptr, grant_idx, ch_q;
  logic                    grant_any, grant_fire;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [BANK_W-1:0]       w_bank, bank_q, cur_bank;
  logic [ROW_W-1:0]        w_row, row_q, cur_row;
  logic [COL_W-1:0]        w_col, col_q, cur_col;
  logic                    w_rw, rw_q, cur_rw;
  logic [DATA_WIDTH-1:0]   w_wdata, wdata_q, cur_wdata, rdata_q;
  logic [NUM_OF_BANKS-1:0] open_q;
  logic [ROW_W-1:0]        row_tab [NUM_OF_BANKS];
  logic [RI_W-1:0]         ref_cnt;
  logic                    ref_pending, ref_wrap;
  logic [2:0]              cmd_q, cmd_d;
  logic [BANK_W-1:0]       bank_o, bank_d;
  logic [ROW_W-1:0]        row_o, row_d;
  logic [COL_W-1:0]        col_o, col_d;
  logic [DATA_WIDTH-1:0]   wdata_o, wdata_d;

  // Round-robin search starting at rr_ptr, the channel after the last winner.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
    w_addr  = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_col   = w_addr[COL_W-1:0];
    w_row   = w_addr[COL_W +: ROW_W];
    w_bank  = w_addr[COL_W+ROW_W +: BANK_W];
    w_rw    = bus.req_rw[grant_idx];
    w_wdata = bus.req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_fire    = (state == S_IDLE) && !ref_pending && grant_any;
  assign bus.req_ready = (grant_fire && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
  assign ref_wrap      = (ref_cnt == RI_W'(REFRESH_INTERVAL - 1));

  always_comb begin
    state_d   = state;
    cnt_d     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    cmd_d     = CMD_NOP;
    bank_d    = '0;
    row_d     = '0;
    col_d     = '0;
    wdata_d   = '0;
    cur_bank  = (state == S_IDLE) ? w_bank  : bank_q;
    cur_row   = (state == S_IDLE) ? w_row   : row_q;
    cur_col   = (state == S_IDLE) ? w_col   : col_q;
    cur_rw    = (state == S_IDLE) ? w_rw    : rw_q;
    cur_wdata = (state == S_IDLE) ? w_wdata : wdata_q;
    case (state)
      S_IDLE: begin
        if (ref_pending)
          state_d = (|open_q) ? S_PREA : S_REF;
        else if (grant_any) begin
          if (open_q[w_bank] && row_tab[w_bank] == w_row) state_d = S_ACCESS;
          else if (open_q[w_bank])                        state_d = S_PRE;
          else                                            state_d = S_ACT;
        end
      end
      S_ACT, S_RCD_WAIT:   state_d = (cnt == '0) ? S_ACCESS : S_RCD_WAIT;
      S_ACCESS:            state_d = rw_q ? S_RACK : S_CL_WAIT;
      S_CL_WAIT:           state_d = (cnt == '0) ? S_RACK : S_CL_WAIT;
      S_PRE, S_RP_WAIT:    state_d = (cnt == '0) ? S_ACT : S_RP_WAIT;
      S_RACK:              state_d = S_IDLE;
      S_PREA, S_PREA_WAIT: state_d = (cnt == '0) ? S_REF : S_PREA_WAIT;
      S_REF, S_RFC_WAIT:   state_d = (cnt == '0) ? S_IDLE : S_RFC_WAIT;
      default:             state_d = S_IDLE;
    endcase
    // Commands are registered from the state being entered so they line up with it.
    if (state_d != state) begin
      case (state_d)
        S_ACT: begin
          cnt_d  = CNT_W'(T_RCD - 1);
          cmd_d  = CMD_ACT;
          bank_d = cur_bank;
          row_d  = cur_row;
        end
        S_PRE: begin
          cnt_d  = CNT_W'(T_RP - 1);
          cmd_d  = CMD_PRE;
          bank_d = cur_bank;
        end
        S_ACCESS: begin
          cmd_d   = cur_rw ? CMD_WR : CMD_RD;
          bank_d  = cur_bank;
          col_d   = cur_col;
          wdata_d = cur_rw ? cur_wdata : '0;
        end
        S_CL_WAIT: cnt_d = CNT_W'(T_CL - 1);
        S_PREA: begin
          cnt_d = CNT_W'(T_RP - 1);
          cmd_d = CMD_PREA;
        end
        S_REF: begin
          cnt_d = CNT_W'(T_RFC - 1);
          cmd_d = CMD_REF;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      ch_q        <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      open_q      <= '0;
      for (int b = 0; b < NUM_OF_BANKS; b++) row_tab[b] <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      cmd_q       <= CMD_NOP;
      bank_o      <= '0;
      row_o       <= '0;
      col_o       <= '0;
      wdata_o     <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      cmd_q   <= cmd_d;
      bank_o  <= bank_d;
      row_o   <= row_d;
      col_o   <= col_d;
      wdata_o <= wdata_d;
      if (grant_fire) begin
        ch_q    <= grant_idx;
        bank_q  <= w_bank;
        row_q   <= w_row;
        col_q   <= w_col;
        rw_q    <= w_rw;
        wdata_q <= w_wdata;
        rr_ptr  <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + CH_W'(1);
      end
      if (state == S_CL_WAIT && cnt == '0) rdata_q <= bus.dram_rdata;
      if (state == S_ACT) begin
        open_q[bank_q]  <= 1'b1;
        row_tab[bank_q] <= row_q;
      end
      if (state == S_PRE) open_q[bank_q] <= 1'b0;
      if (state == S_REF) open_q <= '0;
      // An expiry coinciding with REF is kept so refresh spacing stays exact.
      ref_cnt <= ref_wrap ? '0 : ref_cnt + RI_W'(1);
      if (ref_wrap)            ref_pending <= 1'b1;
      else if (state == S_REF) ref_pending <= 1'b0;
    end
  end

  assign bus.dram_cmd     = cmd_q;
  assign bus.dram_bank    = bank_o;
  assign bus.dram_row     = row_o;
  assign bus.dram_col     = col_o;
  assign bus.dram_wdata   = wdata_o;
  assign bus.rsp_valid    = (state == S_RACK) ? (NUM_REQ'(1) << ch_q) : '0;
  assign bus.rsp_data     = (state == S_RACK && !rw_q) ? rdata_q : '0;
  assign bus.refresh_busy = (state == S_PREA) || (state == S_PREA_WAIT) ||
                            (state == S_REF)  || (state == S_RFC_WAIT);
endmodule
